// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with per-register pending-write scoreboard.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   rd_sel   : NREAD packed read addresses      -> rd_data : NREAD packed read words
//   rd_busy  : per read port, selected register awaits a write
//   wr_en/wr_addr/wr_data : NWRITE packed write ports, higher index wins
//   iss_en/iss_addr       : mark a destination register pending
//   flush    : clear every pending mark
//   busy_vec : registered pending-mark vector
module regfile_sb #(
   parameter int BITSIZE = 32,
   parameter int REGSIZE = 32,
   parameter int NREAD   = 2,
   parameter int NWRITE  = 2,
   localparam int AW     = $clog2(REGSIZE)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREAD*AW-1:0]       rd_sel,
   output logic [NREAD*BITSIZE-1:0]  rd_data,
   output logic [NREAD-1:0]          rd_busy,
   input  logic [NWRITE-1:0]         wr_en,
   input  logic [NWRITE*AW-1:0]      wr_addr,
   input  logic [NWRITE*BITSIZE-1:0] wr_data,
   input  logic                      iss_en,
   input  logic [AW-1:0]             iss_addr,
   input  logic                      flush,
   output logic [REGSIZE-1:0]        busy_vec
);
   logic [BITSIZE-1:0] regs_q [REGSIZE];
   logic [BITSIZE-1:0] regs_d [REGSIZE];
   logic [REGSIZE-1:0] busy_q, busy_d;
   logic               wr_hit;
   // Loops start at register 1 and compare full-width addresses, so x0 and
   // out-of-range addresses never match anything.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      for (int r = 1; r < REGSIZE; r++) begin
         for (int w = 0; w < NWRITE; w++)
            if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == r) begin
               regs_d[r] = wr_data[w*BITSIZE +: BITSIZE];
               busy_d[r] = 1'b0;
            end
         if (iss_en && int'(iss_addr) == r) busy_d[r] = 1'b1;
      end
      if (flush) busy_d = '0;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         regs_q <= '{default: '0};
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   // Reads bypass same-cycle writes; a pending mark is hidden by a same-cycle
   // write unless a same-cycle issue re-marks the register.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      wr_hit  = 1'b0;
      if (rst)
         for (int p = 0; p < NREAD; p++)
            for (int r = 1; r < REGSIZE; r++)
               if (int'(rd_sel[p*AW +: AW]) == r) begin
                  wr_hit = 1'b0;
                  rd_data[p*BITSIZE +: BITSIZE] = regs_q[r];
                  for (int w = 0; w < NWRITE; w++)
                     if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == r) begin
                        rd_data[p*BITSIZE +: BITSIZE] = wr_data[w*BITSIZE +: BITSIZE];
                        wr_hit = 1'b1;
                     end
                  rd_busy[p] = busy_q[r] && !(wr_hit && !(iss_en && int'(iss_addr) == r));
               end
   end
   assign busy_vec = busy_q;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scoreboard bench for regfile_sb.
module tb_regfile_sb;
   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  rd_sel;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        iss_en;
   logic [4:0]  iss_addr;
   logic        flush;
   logic [31:0] busy_vec;
   int          n_tests = 0;
   int          n_fail = 0;
   typedef struct {
      string       tag;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  rb;
      logic [31:0] bv;
   } exp_t;
   exp_t sb[$];
   regfile_sb dut (
      .clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
      .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec)
   );
   always #5 clk = ~clk;
   task automatic drv(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] w0,
                      input logic [4:0] a1, input logic [31:0] w1, input logic ie,
                      input logic [4:0] ia, input logic fl, input logic [4:0] r0,
                      input logic [4:0] r1);
      wr_en    = we;
      wr_addr  = {a1, a0};
      wr_data  = {w1, w0};
      iss_en   = ie;
      iss_addr = ia;
      flush    = fl;
      rd_sel   = {r1, r0};
   endtask
   task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
      drv(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, r0, r1);
   endtask
   task automatic exp(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [1:0] rb, input logic [31:0] bv);
      exp_t e;
      e.tag = tag; e.d0 = d0; e.d1 = d1; e.rb = rb; e.bv = bv;
      sb.push_back(e);
   endtask
   task automatic cmp(input string tag, input string f, input logic [31:0] got,
                      input logic [31:0] want);
      n_tests++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s.%s got %h expected %h", tag, f, got, want);
      end
   endtask
   task automatic chk_now();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         cmp(e.tag, "rd_data0", rd_data[31:0], e.d0);
         cmp(e.tag, "rd_data1", rd_data[63:32], e.d1);
         cmp(e.tag, "rd_busy", {30'd0, rd_busy}, {30'd0, e.rb});
         cmp(e.tag, "busy_vec", busy_vec, e.bv);
      end
   endtask
   task automatic chk();
      @(negedge clk);
      chk_now();
   endtask
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   initial begin
      rst = 1'b0;
      drv(2'b01, 5'd5, 32'h1234, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd5, 5'd0);
      exp("in_reset", 32'h0, 32'h0, 2'b00, 32'h0);
      chk();
      nxt();
      exp("in_reset_edge", 32'h0, 32'h0, 2'b00, 32'h0);
      chk();
      idle(5'd0, 5'd0);
      rst = 1'b1;
      for (int a = 0; a < 32; a++) begin
         nxt();
         idle(5'(a), 5'(31 - a));
         exp("post_reset", 32'h0, 32'h0, 2'b00, 32'h0);
         chk();
      end
      nxt();
      drv(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
      exp("bypass_x5", 32'hDEADBEEF, 32'h0, 2'b00, 32'h0);
      chk();
      nxt();
      idle(5'd5, 5'd0);
      exp("stored_x5", 32'hDEADBEEF, 32'h0, 2'b00, 32'h0);
      chk();
      nxt();
      drv(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 1'b0, 5'd7, 5'd5);
      exp("collide_x7", 32'h22, 32'hDEADBEEF, 2'b00, 32'h0);
      chk();
      nxt();
      idle(5'd7, 5'd7);
      exp("stored_x7", 32'h22, 32'h22, 2'b00, 32'h0);
      chk();
      nxt();
      drv(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0);
      exp("issue_x9", 32'h0, 32'h0, 2'b00, 32'h0);
      chk();
      nxt();
      idle(5'd9, 5'd0);
      exp("idle1_x9", 32'h0, 32'h0, 2'b01, 32'h200);
      chk();
      nxt();
      exp("idle2_x9", 32'h0, 32'h0, 2'b01, 32'h200);
      chk();
      nxt();
      drv(2'b10, 5'd0, 32'h0, 5'd9, 32'h5, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0);
      exp("write_x9", 32'h5, 32'h0, 2'b00, 32'h200);
      chk();
      nxt();
      idle(5'd9, 5'd0);
      exp("cleared_x9", 32'h5, 32'h0, 2'b00, 32'h0);
      chk();
      nxt();
      drv(2'b01, 5'd9, 32'h6, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0);
      exp("iss_wr_x9", 32'h6, 32'h0, 2'b00, 32'h0);
      chk();
      nxt();
      idle(5'd9, 5'd0);
      exp("iss_wr_kept", 32'h6, 32'h0, 2'b01, 32'h200);
      chk();
      nxt();
      drv(2'b01, 5'd9, 32'h7, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0);
      exp("iss_wr_busy", 32'h7, 32'h0, 2'b01, 32'h200);
      chk();
      nxt();
      drv(2'b01, 5'd9, 32'h8, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9);
      exp("wr_hides_busy", 32'h0, 32'h8, 2'b00, 32'h200);
      chk();
      nxt();
      idle(5'd9, 5'd0);
      exp("x9_final", 32'h8, 32'h0, 2'b00, 32'h0);
      chk();
      nxt();
      drv(2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
      exp("x0_write", 32'h0, 32'h0, 2'b00, 32'h0);
      chk();
      nxt();
      idle(5'd0, 5'd0);
      exp("x0_after", 32'h0, 32'h0, 2'b00, 32'h0);
      chk();
      nxt();
      drv(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd4);
      exp("issue_x3", 32'h0, 32'h0, 2'b00, 32'h0);
      chk();
      nxt();
      drv(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd3, 5'd4);
      exp("issue_x4", 32'h0, 32'h0, 2'b01, 32'h8);
      chk();
      nxt();
      drv(2'b01, 5'd10, 32'hABCD, 5'd0, 32'h0, 1'b1, 5'd6, 1'b1, 5'd3, 5'd4);
      exp("flush_cycle", 32'h0, 32'h0, 2'b11, 32'h18);
      chk();
      nxt();
      idle(5'd10, 5'd6);
      exp("after_flush", 32'hABCD, 32'h0, 2'b00, 32'h0);
      chk();
      nxt();
      drv(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b0, 5'd5, 5'd7);
      exp("pre_rst", 32'hDEADBEEF, 32'h22, 2'b00, 32'h0);
      chk();
      nxt();
      idle(5'd5, 5'd12);
      exp("pre_rst_busy", 32'hDEADBEEF, 32'h0, 2'b10, 32'h1000);
      #2;
      chk_now();
      rst = 1'b0;
      #1;
      exp("async_rst", 32'h0, 32'h0, 2'b00, 32'h0);
      chk_now();
      nxt();
      drv(2'b01, 5'd5, 32'h99, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5, 5'd12);
      exp("rst_ignores", 32'h0, 32'h0, 2'b00, 32'h0);
      chk();
      nxt();
      idle(5'd5, 5'd12);
      rst = 1'b1;
      exp("rst_released", 32'h0, 32'h0, 2'b00, 32'h0);
      chk();
      nxt();
      idle(5'd7, 5'd10);
      exp("data_discarded", 32'h0, 32'h0, 2'b00, 32'h0);
      chk();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter BITSIZE, default 32: register data width.
REQ-002 Parameter REGSIZE, default 32: number of registers; address width AW = $clog2(REGSIZE).
REQ-003 Parameter NREAD, default 2: number of read ports.
REQ-004 Parameter NWRITE, default 2: number of write ports; a higher port index has higher priority.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-007 rd_sel  input  NREAD*AW  read addresses; port p occupies bits [p*AW +: AW].
REQ-008 rd_data  output  NREAD*BITSIZE  read data; port p occupies bits [p*BITSIZE +: BITSIZE].
REQ-009 rd_busy  output  NREAD  per port: the selected register has a pending write.
REQ-010 wr_en  input  NWRITE  per-port write enable.
REQ-011 wr_addr  input  NWRITE*AW  write addresses, packed as rd_sel.
REQ-012 wr_data  input  NWRITE*BITSIZE  write data, packed as rd_data.
REQ-013 iss_en  input  1  issue strobe; marks iss_addr as pending.
REQ-014 iss_addr  input  AW  destination register of the issued instruction.
REQ-015 flush  input  1  synchronous clear of all pending marks.
REQ-016 busy_vec  output  REGSIZE  registered pending-mark vector; bit 0 is always 0.

Function
REQ-017 Storage: REGSIZE x BITSIZE registers; register 0 reads 0 at all times and is never written.
REQ-018 Write: at each rising edge, every port w with wr_en[w]=1 and a nonzero address writes wr_data[w] to that address.
REQ-019 Same-address write collision: the highest-index enabled port wins; the other ports' data is discarded.
REQ-020 Read: combinational on every port, zero-cycle latency.
REQ-021 Read bypass: if an enabled write port targets rd_sel[p] (nonzero) in the current cycle, rd_data[p] returns that port's wr_data (highest-priority winner); otherwise it returns stored content.
REQ-022 Pending-mark set: iss_en=1 with nonzero iss_addr sets busy[iss_addr] at the edge.
REQ-023 Pending-mark clear: an enabled write to a nonzero address clears busy[addr] at the edge.
REQ-024 Simultaneous issue and write to the same register: busy stays set, because the newer issue dominates; the data write still occurs.
REQ-025 Flush has priority over issue and write-clear: all busy bits become 0 at the edge; writes to storage still occur.
REQ-026 rd_busy[p] = busy[rd_sel[p]] AND NOT (a write to rd_sel[p] in the current cycle, with no same-cycle issue to it); rd_busy for address 0 is always 0.
REQ-027 Issue or write to address 0 has no effect on storage or busy.
REQ-028 Address values >= REGSIZE (non-power-of-2 REGSIZE): writes and issues are ignored; reads return 0 with busy 0.

Reset
REQ-029 rst=0 asynchronously clears all registers to 0 and all busy bits to 0, independent of clk.
REQ-030 While rst=0: rd_data = 0 on all ports, rd_busy = 0, busy_vec = 0; writes, issues and flush are ignored.
REQ-031 Deassertion of rst takes effect at the next rising edge; reset asserted mid-operation discards all pending marks and data.

Verification
REQ-032 Reset, then read x0..x31 on both ports -> all data 0, rd_busy 0, busy_vec 0.
REQ-033 Write port0 x5=0xDEADBEEF while rd_sel0=5 in the same cycle -> rd_data0=0xDEADBEEF (bypass); the next cycle still reads 0xDEADBEEF from storage.
REQ-034 Both ports write x7 (port0 0x11, port1 0x22) -> x7=0x22; a same-cycle read of x7 returns 0x22.
REQ-035 Issue x9, then two idle cycles, then write x9=0x5 -> busy_vec[9]=1 for those cycles and rd_busy=0 during the write cycle; busy clears after the edge; the same-edge issue+write of x9 leaves busy_vec[9]=1.
REQ-036 Write x0=0xFFFFFFFF with iss_addr=0 -> x0 reads 0 and busy_vec[0]=0.
REQ-037 Issue x3 and x4, then flush together with an issue of x6 -> busy_vec all 0; assert rst mid-cycle with data stored -> immediate zero outputs without a clock edge.
